multicycle_fetch: RTL and testbench
===================================

Name: multicycle_fetch

Overview:
- Instruction-fetch front end for the multicycle MIPS core; sits directly upstream of the per-instruction state controller.
- Holds the PC and issues one instruction-memory read per fetch request from the controller.
- Latches the returned word into the instruction register (IR) that the controller and decoder consume.
- Applies PC redirects from execute/writeback (branch, jump).

Parameters:
RESET_PC, 32'hBFC0_0000, PC value loaded on reset.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-low reset
fetch_enable  input  1  high while the state controller is in its fetch state; requests a new instruction
pc_redirect_valid  input  1  one-cycle pulse: load pc_redirect as next fetch PC
pc_redirect  input  32  redirect target (branch/jump)
iresp_data_ok  input  1  memory returns read data this cycle
iresp_data  input  32  instruction word, valid when iresp_data_ok=1
ireq_valid  output  1  instruction read request outstanding
ireq_addr  output  32  read address, word aligned
instruction  output  32  IR, registered; 0 means no valid instruction
pc  output  32  PC of next/current fetch
fetch_busy  output  1  high in WAIT or DISCARD

Behaviour:
- Reset (reset=0 at a rising edge) overrides everything, including mid-request:
  - pc=RESET_PC, instruction=0, ireq_valid=0, ireq_addr=RESET_PC, state=IDLE, fetch_busy=0.
  - A memory response arriving while reset is low is ignored.
- All outputs are registered; fetch_busy=(state!=IDLE).
- States: IDLE, WAIT, DISCARD. Encoding is free.
- IDLE:
  - pc_redirect_valid=1: pc<=pc_redirect with bits[1:0] forced to 00. If fetch_enable is also 1, the fetch issues to the redirected address at this same edge: ireq_addr<={pc_redirect[31:2],2'b00}.
  - Otherwise, fetch_enable=1: ireq_valid<=1, ireq_addr<=pc, instruction<=0, go WAIT.
  - Otherwise: hold all state.
- WAIT:
  - ireq_valid and ireq_addr are held stable; fetch_enable is ignored.
  - iresp_data_ok=1 with no redirect and no pending redirect: instruction<=iresp_data, pc<=pc+4 (mod 2^32, wraps 32'hFFFF_FFFC to 0), ireq_valid<=0, go IDLE.
  - pc_redirect_valid=1 without iresp_data_ok: pc<=aligned redirect, set pending, go DISCARD. The request remains outstanding.
  - pc_redirect_valid=1 and iresp_data_ok=1 in the same cycle: the redirect wins. The data is dropped, instruction stays 0, pc<=aligned redirect, ireq_valid<=0, go IDLE.
- DISCARD:
  - ireq_valid stays 1 until iresp_data_ok.
  - On iresp_data_ok: data dropped, instruction stays 0, pc unchanged (already the redirect target), ireq_valid<=0, go IDLE.
  - A further redirect in DISCARD overwrites pc; the last redirect wins.
- Latency: minimum 2 cycles from fetch_enable sampled to instruction valid (issue edge plus response edge). Memory may stretch WAIT indefinitely.
- instruction=0 is treated downstream as "no instruction". Discarded fetches therefore leave the controller in its fetch state, and it re-requests.
- instruction only changes on an issue (to 0) or on a completed, non-discarded response.
- At most one request is outstanding; there is no queueing.

Test Plan:
- Reset then fetch: reset=0 for 2 cycles, release, fetch_enable=1, memory returns 32'h2008_0005 one cycle after ireq_valid -> ireq_addr=BFC0_0000, instruction=2008_0005 two edges after issue, pc=BFC0_0004, ireq_valid=0.
- Stretched memory: hold iresp_data_ok=0 for 5 cycles, toggle fetch_enable -> ireq_valid/ireq_addr stable, instruction=0, fetch_busy=1 throughout; completes normally on data_ok.
- Redirect in IDLE: pc_redirect_valid=1, pc_redirect=32'h0000_1003, fetch_enable=1 same cycle -> pc=0000_1000, ireq_addr=0000_1000.
- Redirect during WAIT: redirect to 0000_2000 two cycles before data_ok (data 32'h1111_1111) -> state DISCARD, instruction stays 0, pc=0000_2000; next fetch uses 0000_2000.
- Redirect coincident with data_ok: data 32'hAAAA_AAAA dropped, instruction=0, pc=target, state IDLE.
- Mid-request reset and wrap: reset=0 while in WAIT -> all outputs at reset values next edge. Separately, redirect to FFFF_FFFC and fetch -> pc wraps to 0000_0000.

Source files
------------

// File: rtl/multicycle_fetch.sv
// rtl/multicycle_fetch.sv - instruction-fetch front end: PC, single outstanding I-mem read, IR latch
module multicycle_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_enable,
  input  logic        pc_redirect_valid,
  input  logic [31:0] pc_redirect,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output logic        ireq_valid,
  output logic [31:0] ireq_addr,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic        fetch_busy
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;

  logic [1:0]  state;
  logic [31:0] redirect_aligned;

  assign redirect_aligned = {pc_redirect[31:2], 2'b00};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      pc          <= RESET_PC;
      instruction <= 32'h0;
      ireq_valid  <= 1'b0;
      ireq_addr   <= RESET_PC;
      fetch_busy  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pc_redirect_valid) begin
            pc <= redirect_aligned;
          end
          // A redirect in the same cycle as a fetch request steers the fetch itself.
          if (fetch_enable) begin
            ireq_valid  <= 1'b1;
            ireq_addr   <= pc_redirect_valid ? redirect_aligned : pc;
            instruction <= 32'h0;
            state       <= ST_WAIT;
            fetch_busy  <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (pc_redirect_valid) begin
            pc <= redirect_aligned;
            if (iresp_data_ok) begin
              ireq_valid <= 1'b0;
              state      <= ST_IDLE;
              fetch_busy <= 1'b0;
            end else begin
              state <= ST_DISCARD;
            end
          end else if (iresp_data_ok) begin
            instruction <= iresp_data;
            pc          <= pc + 32'd4;
            ireq_valid  <= 1'b0;
            state       <= ST_IDLE;
            fetch_busy  <= 1'b0;
          end
        end
        ST_DISCARD: begin
          if (pc_redirect_valid) begin
            pc <= redirect_aligned;
          end
          // The stale response still has to drain before a new request may issue.
          if (iresp_data_ok) begin
            ireq_valid <= 1'b0;
            state      <= ST_IDLE;
            fetch_busy <= 1'b0;
          end
        end
        default: begin
          state      <= ST_IDLE;
          ireq_valid <= 1'b0;
          fetch_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_fetch.sv
// tb/tb_multicycle_fetch.sv - randomized and directed check of multicycle_fetch against a transaction model
module tb_multicycle_fetch;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        clk;
  logic        reset;
  logic        fetch_enable;
  logic        pc_redirect_valid;
  logic [31:0] pc_redirect;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        fetch_busy;

  multicycle_fetch #(.RESET_PC(RST_PC)) dut (
    .clk(clk),
    .reset(reset),
    .fetch_enable(fetch_enable),
    .pc_redirect_valid(pc_redirect_valid),
    .pc_redirect(pc_redirect),
    .iresp_data_ok(iresp_data_ok),
    .iresp_data(iresp_data),
    .ireq_valid(ireq_valid),
    .ireq_addr(ireq_addr),
    .instruction(instruction),
    .pc(pc),
    .fetch_busy(fetch_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: one optional outstanding request, possibly doomed by a redirect.
  logic [31:0] m_pc;
  logic [31:0] m_ir;
  logic [31:0] m_addr;
  bit          m_out;
  bit          m_doomed;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_step(input bit rst, input bit fe, input bit rv, input logic [31:0] rt,
                            input bit ok, input logic [31:0] d);
    logic [31:0] tgt;
    tgt = rt & 32'hFFFF_FFFC;
    if (!rst) begin
      m_pc = RST_PC; m_ir = 0; m_addr = RST_PC; m_out = 0; m_doomed = 0;
    end else if (!m_out) begin
      if (rv) m_pc = tgt;
      if (fe) begin
        m_out = 1; m_doomed = 0; m_addr = m_pc; m_ir = 0;
      end
    end else if (rv) begin
      m_pc = tgt;
      if (ok) begin m_out = 0; m_doomed = 0; end
      else m_doomed = 1;
    end else if (ok) begin
      if (!m_doomed) begin
        m_ir = d;
        m_pc = m_pc + 32'd4;
      end
      m_out = 0; m_doomed = 0;
    end
  endtask

  task automatic step(input bit rst, input bit fe, input bit rv, input logic [31:0] rt,
                      input bit ok, input logic [31:0] d);
    reset = rst; fetch_enable = fe; pc_redirect_valid = rv; pc_redirect = rt;
    iresp_data_ok = ok; iresp_data = d;
    model_step(rst, fe, rv, rt, ok, d);
    @(posedge clk);
    #1;
    check("pc", pc, m_pc);
    check("instruction", instruction, m_ir);
    check("ireq_valid", {31'b0, ireq_valid}, {31'b0, m_out});
    if (m_out) check("ireq_addr", ireq_addr, m_addr);
    check("fetch_busy", {31'b0, fetch_busy}, {31'b0, m_out});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 32'h0, 0, 32'h0);
  endtask

  initial begin
    reset = 0; fetch_enable = 0; pc_redirect_valid = 0; pc_redirect = 0;
    iresp_data_ok = 0; iresp_data = 0;

    // Reset then a simple fetch.
    step(0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    step(0, 1, 0, 0, 0, 0);
    check("reset_pc", pc, RST_PC);
    check("reset_addr", ireq_addr, RST_PC);
    step(1, 1, 0, 0, 0, 0);
    check("first_addr", ireq_addr, 32'hBFC0_0000);
    step(1, 0, 0, 0, 1, 32'h2008_0005);
    check("first_ir", instruction, 32'h2008_0005);
    check("first_pc", pc, 32'hBFC0_0004);

    // Stretched memory with fetch_enable toggling.
    step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, i[0], 0, 0, 0, 32'h5555_0000);
    check("stretch_addr", ireq_addr, 32'hBFC0_0004);
    step(1, 0, 0, 0, 1, 32'h0123_4567);
    check("stretch_ir", instruction, 32'h0123_4567);

    // Redirect in IDLE with a simultaneous fetch.
    step(1, 1, 1, 32'h0000_1003, 0, 0);
    check("idle_redir_addr", ireq_addr, 32'h0000_1000);
    check("idle_redir_pc", pc, 32'h0000_1000);
    step(1, 0, 0, 0, 1, 32'hCAFE_0001);

    // Redirect during WAIT, response arrives two cycles later.
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 1, 32'h0000_2000, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 32'h1111_1111);
    check("discard_ir", instruction, 32'h0);
    check("discard_pc", pc, 32'h0000_2000);
    step(1, 1, 0, 0, 0, 0);
    check("after_discard_addr", ireq_addr, 32'h0000_2000);
    step(1, 0, 0, 0, 1, 32'h2222_2222);

    // Redirect coincident with the response.
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 1, 32'h0000_3000, 1, 32'hAAAA_AAAA);
    check("coinc_ir", instruction, 32'h0);
    check("coinc_pc", pc, 32'h0000_3000);

    // Reset while a request is outstanding.
    step(1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h7777_7777);
    check("midreset_valid", {31'b0, ireq_valid}, 32'h0);
    check("midreset_pc", pc, RST_PC);

    // PC wrap.
    step(1, 1, 1, 32'hFFFF_FFFC, 0, 0);
    step(1, 0, 0, 0, 1, 32'h3333_3333);
    check("wrap_pc", pc, 32'h0000_0000);

    // Randomized traffic; responses only while a request is outstanding.
    for (int i = 0; i < 3000; i++) begin
      bit rst, fe, rv, ok;
      rst = ($urandom_range(0, 99) != 0);
      fe  = ($urandom_range(0, 1) == 1);
      rv  = ($urandom_range(0, 7) == 0);
      ok  = m_out && ($urandom_range(0, 2) == 0);
      step(rst, fe, rv, $urandom, ok, $urandom | 32'h1);
    end
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
